// File: rtl/afe_udma_ch_arbiter.sv
// -----------------------------------------------------------------------------
// afe_udma_ch_arbiter
//
// Round-robin arbiter that shares one uDMA RX write port between NUM_CH AFE
// readout channels. Each channel offers a sample and the current L2 address
// from its own address generator. The winner is registered into a single
// output slot toward the uDMA, and the winner's valid-transfer strobe is
// pulsed so its address generator advances its pointer and byte counter.
//
// Handshake semantics (applies to every valid/ready pair on this block):
//   a transfer happens on a rising clk_i edge where valid and ready are both 1.
//   Channel side: ch_valid_i[i] (qualified by ch_en_i[i]) is the request and
//   ch_ready_o[i] is the one-hot accept. uDMA side: udma_valid_o/udma_ready_i;
//   while udma_valid_o=1 and udma_ready_i=0 the udma_* outputs hold stable.
//
// Optional feature (macro AFE_ARB_STALL_CNT_EN):
//   adds stall_cnt_o, a saturating 16-bit count of cycles with
//   udma_valid_o=1 and udma_ready_i=0, cleared by rst_i or cfg_clr_i.
//
// Ports:
//   clk_i           clock
//   rst_i           synchronous active-high reset
//   cfg_clr_i       flush output slot, reset round-robin pointer
//   ch_en_i         per-channel enable (low masks the request)
//   ch_valid_i      per-channel sample valid
//   ch_data_i       packed samples, channel i at [i*DATA_WIDTH +: DATA_WIDTH]
//   ch_addr_i       packed L2 addresses, channel i at [i*AWIDTH +: AWIDTH]
//   ch_ready_o      one-hot accept of the granted channel
//   ch_vtransfer_o  one-hot valid-transfer strobe (same as ch_ready_o)
//   udma_valid_o    output slot holds a beat
//   udma_data_o     registered sample
//   udma_addr_o     registered L2 address
//   udma_ch_o       source channel of the beat
//   stall_cnt_o     (AFE_ARB_STALL_CNT_EN only) stall cycle counter
//   udma_ready_i    uDMA accepts the beat
//   dbg_state_o     slot FSM state (0 = EMPTY, 1 = FULL)
// -----------------------------------------------------------------------------
module afe_udma_ch_arbiter #(
  parameter int NUM_CH     = 4,
  parameter int DATA_WIDTH = 32,
  parameter int AWIDTH     = 18
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         cfg_clr_i,
  input  logic [NUM_CH-1:0]            ch_en_i,
  input  logic [NUM_CH-1:0]            ch_valid_i,
  input  logic [NUM_CH*DATA_WIDTH-1:0] ch_data_i,
  input  logic [NUM_CH*AWIDTH-1:0]     ch_addr_i,
  output logic [NUM_CH-1:0]            ch_ready_o,
  output logic [NUM_CH-1:0]            ch_vtransfer_o,
  output logic                         udma_valid_o,
  output logic [DATA_WIDTH-1:0]        udma_data_o,
  output logic [AWIDTH-1:0]            udma_addr_o,
  output logic [$clog2(NUM_CH)-1:0]    udma_ch_o,
`ifdef AFE_ARB_STALL_CNT_EN
  output logic [15:0]                  stall_cnt_o,
`endif
  input  logic                         udma_ready_i,
  output logic                         dbg_state_o
);

  // NUM_CH is 2..8, so $clog2 is always at least 1 bit.
  localparam int CW = $clog2(NUM_CH);

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  state_t state_q, state_d;

  logic [CW-1:0]         ptr_q, ptr_d;
  logic [DATA_WIDTH-1:0] data_q;
  logic [AWIDTH-1:0]     addr_q;
  logic [CW-1:0]         ch_q;

  logic [NUM_CH-1:0]     req;
  logic [2*NUM_CH-1:0]   req_dbl;
  logic [NUM_CH-1:0]     req_rot;
  logic                  grant_hit;
  logic [CW-1:0]         grant_off;
  logic [CW:0]           grant_sum;
  logic [CW-1:0]         grant_idx;
  logic [CW-1:0]         ptr_after_grant;
  logic                  slot_free;
  logic                  do_grant;
  logic [NUM_CH-1:0]     grant_onehot;
  logic [DATA_WIDTH-1:0] sel_data;
  logic [AWIDTH-1:0]     sel_addr;

  // ---------------------------------------------------------------------------
  // Request qualification and round-robin search
  // ---------------------------------------------------------------------------
  assign req = ch_valid_i & ch_en_i;

  // Rotate the requests so bit 0 is the channel at ptr; the lowest set bit of
  // the rotated vector is then the first requester searching upward from ptr.
  assign req_dbl = {req, req};
  assign req_rot = NUM_CH'(req_dbl >> ptr_q);

  always_comb begin
    grant_hit = 1'b0;
    grant_off = '0;
    // Descending scan so the lowest set bit is the last (winning) assignment.
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (req_rot[k]) begin
        grant_hit = 1'b1;
        grant_off = CW'(k);
      end
    end
  end

  // Undo the rotation: (ptr + offset) mod NUM_CH. The sum is one bit wider so
  // the wrap works for non-power-of-two channel counts too.
  assign grant_sum = {1'b0, ptr_q} + {1'b0, grant_off};
  assign grant_idx = (grant_sum >= (CW+1)'(NUM_CH)) ?
                     CW'(grant_sum - (CW+1)'(NUM_CH)) : grant_sum[CW-1:0];

  assign ptr_after_grant = (grant_idx == CW'(NUM_CH - 1)) ? '0 : grant_idx + CW'(1);

  // ---------------------------------------------------------------------------
  // Slot FSM: next state, pointer update and grant qualification
  // ---------------------------------------------------------------------------
  // The slot can take a new beat when it is empty, or when its current beat
  // leaves this cycle; the latter gives one beat per cycle sustained.
  assign slot_free = (state_q == ST_EMPTY) || udma_ready_i;

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    do_grant = 1'b0;
    if (rst_i) begin
      // Registers are cleared by the reset branch; suppress the grant so no
      // channel sees an accept strobe for a beat that will be discarded.
      do_grant = 1'b0;
    end else if (cfg_clr_i) begin
      // Flush wins over everything, including a beat accepted this cycle.
      state_d = ST_EMPTY;
      ptr_d   = '0;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (grant_hit) begin
            do_grant = 1'b1;
            state_d  = ST_FULL;
            ptr_d    = ptr_after_grant;
          end
        end
        ST_FULL: begin
          if (udma_ready_i) begin
            if (grant_hit) begin
              do_grant = 1'b1;
              state_d  = ST_FULL;
              ptr_d    = ptr_after_grant;
            end else begin
              state_d = ST_EMPTY;
            end
          end
        end
        default: begin
          state_d = ST_EMPTY;
        end
      endcase
    end
  end

  // slot_free is already folded into the FSM decisions above; kept as a
  // named term for readability of the handshake.
  assign grant_onehot = (do_grant && slot_free) ? (NUM_CH'(1) << grant_idx) : '0;

  assign ch_ready_o     = grant_onehot;
  assign ch_vtransfer_o = grant_onehot;

  // ---------------------------------------------------------------------------
  // Winner sample/address mux
  // ---------------------------------------------------------------------------
  always_comb begin
    sel_data = '0;
    sel_addr = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (grant_idx == CW'(i)) begin
        sel_data = ch_data_i[i*DATA_WIDTH +: DATA_WIDTH];
        sel_addr = ch_addr_i[i*AWIDTH +: AWIDTH];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // State and output slot registers
  // ---------------------------------------------------------------------------
  // On flush only the state drops to EMPTY; data/addr/channel keep stale
  // contents, which is harmless because udma_valid_o is low.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_EMPTY;
      ptr_q   <= '0;
      data_q  <= '0;
      addr_q  <= '0;
      ch_q    <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      if (do_grant) begin
        data_q <= sel_data;
        addr_q <= sel_addr;
        ch_q   <= grant_idx;
      end
    end
  end

  assign udma_valid_o = (state_q == ST_FULL);
  assign udma_data_o  = data_q;
  assign udma_addr_o  = addr_q;
  assign udma_ch_o    = ch_q;
  assign dbg_state_o  = state_q;

`ifdef AFE_ARB_STALL_CNT_EN
  // ---------------------------------------------------------------------------
  // Stall counter: cycles the uDMA keeps a valid beat waiting
  // ---------------------------------------------------------------------------
  logic [15:0] stall_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || cfg_clr_i) begin
      stall_q <= '0;
    end else if ((state_q == ST_FULL) && !udma_ready_i && (stall_q != 16'hFFFF)) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign stall_cnt_o = stall_q;
`endif

endmodule

// File: tb/tb_afe_udma_ch_arbiter.sv
// -----------------------------------------------------------------------------
// tb_afe_udma_ch_arbiter
//
// Bench for afe_udma_ch_arbiter. A behavioural model keeps the output slot as
// an expected queue of beats and a round-robin pointer as a plain integer;
// each cycle it predicts the granted channel from the eligibility rules and
// compares accepts, strobes and the slot contents. Each channel's address
// generator is emulated by adding 4 to its address on every predicted grant.
// -----------------------------------------------------------------------------
module tb_afe_udma_ch_arbiter;

  localparam int NUM_CH = 4;
  localparam int DW     = 32;
  localparam int AW     = 18;
  localparam int CW     = $clog2(NUM_CH);
  localparam int SW     = CW + AW + DW;

  // ---------------------------------------------------------------------------
  // Clock / reset and DUT
  // ---------------------------------------------------------------------------
  logic                 clk = 1'b0;
  logic                 rst_i;
  logic                 cfg_clr_i;
  logic [NUM_CH-1:0]    ch_en_i;
  logic [NUM_CH-1:0]    ch_valid_i;
  logic [NUM_CH*DW-1:0] ch_data_i;
  logic [NUM_CH*AW-1:0] ch_addr_i;
  logic [NUM_CH-1:0]    ch_ready_o;
  logic [NUM_CH-1:0]    ch_vtransfer_o;
  logic                 udma_valid_o;
  logic [DW-1:0]        udma_data_o;
  logic [AW-1:0]        udma_addr_o;
  logic [CW-1:0]        udma_ch_o;
  logic                 udma_ready_i;
  logic                 dbg_state_o;
`ifdef AFE_ARB_STALL_CNT_EN
  logic [15:0]          stall_cnt_o;
`endif

  always #5 clk = ~clk;

  afe_udma_ch_arbiter #(
    .NUM_CH     (NUM_CH),
    .DATA_WIDTH (DW),
    .AWIDTH     (AW)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .cfg_clr_i      (cfg_clr_i),
    .ch_en_i        (ch_en_i),
    .ch_valid_i     (ch_valid_i),
    .ch_data_i      (ch_data_i),
    .ch_addr_i      (ch_addr_i),
    .ch_ready_o     (ch_ready_o),
    .ch_vtransfer_o (ch_vtransfer_o),
    .udma_valid_o   (udma_valid_o),
    .udma_data_o    (udma_data_o),
    .udma_addr_o    (udma_addr_o),
    .udma_ch_o      (udma_ch_o),
`ifdef AFE_ARB_STALL_CNT_EN
    .stall_cnt_o    (stall_cnt_o),
`endif
    .udma_ready_i   (udma_ready_i),
    .dbg_state_o    (dbg_state_o)
  );

  // ---------------------------------------------------------------------------
  // Reference model state and scoreboard
  // ---------------------------------------------------------------------------
  logic [SW-1:0] exp_q[$];             // beats expected in the output slot
  int            m_ptr;                // next channel to search from
  int            m_stall;              // expected stall count
  logic [AW-1:0] addr_gen [NUM_CH];    // emulated per-channel address generators

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
  endtask

  // Channel that should be granted this cycle, or -1.
  function automatic int pick();
    logic [CW-1:0] ci;
    if (rst_i || cfg_clr_i) return -1;
    if (exp_q.size() != 0 && !udma_ready_i) return -1;
    for (int k = 0; k < NUM_CH; k++) begin
      ci = CW'((m_ptr + k) % NUM_CH);
      if (ch_valid_i[ci] && ch_en_i[ci]) return int'(ci);
    end
    return -1;
  endfunction

  function automatic logic [SW-1:0] make_beat(input int g);
    logic [SW-1:0] b;
    b = '0;
    for (int i = 0; i < NUM_CH; i++)
      if (i == g) b = {CW'(i), ch_addr_i[i*AW +: AW], ch_data_i[i*DW +: DW]};
    return b;
  endfunction

  task automatic pack_addr();
    for (int i = 0; i < NUM_CH; i++) ch_addr_i[i*AW +: AW] = addr_gen[i];
  endtask

  task automatic rand_data();
    for (int i = 0; i < NUM_CH; i++) ch_data_i[i*DW +: DW] = DW'($urandom);
  endtask

  // One clock: compare at the negedge, advance the model at the posedge.
  task automatic cycle();
    int                g;
    logic [NUM_CH-1:0] e;
    logic [CW-1:0]     gi;
    pack_addr();
    @(negedge clk);
    g = pick();
    gi = CW'(g);
    e = (g >= 0) ? (NUM_CH'(1) << gi) : '0;
    check("ch_ready", 64'(ch_ready_o), 64'(e));
    check("ch_vtransfer", 64'(ch_vtransfer_o), 64'(e));
    check("udma_valid", 64'(udma_valid_o), 64'(exp_q.size() != 0));
    check("dbg_state", 64'(dbg_state_o), 64'(exp_q.size() != 0));
    if (exp_q.size() != 0)
      check("udma_beat", 64'({udma_ch_o, udma_addr_o, udma_data_o}), 64'(exp_q[0]));
`ifdef AFE_ARB_STALL_CNT_EN
    check("stall_cnt", 64'(stall_cnt_o), 64'(m_stall));
`endif
    @(posedge clk);
    if (rst_i) begin
      exp_q.delete();
      m_ptr   = 0;
      m_stall = 0;
    end else if (cfg_clr_i) begin
      exp_q.delete();
      m_ptr   = 0;
      m_stall = 0;
    end else begin
      if (exp_q.size() != 0 && !udma_ready_i && m_stall < 65535) m_stall++;
      if (exp_q.size() != 0 && udma_ready_i) void'(exp_q.pop_front());
      if (g >= 0) begin
        exp_q.push_back(make_beat(g));
        m_ptr = (g + 1) % NUM_CH;
        addr_gen[gi] = addr_gen[gi] + AW'(4);
      end
    end
    #1;
  endtask

  task automatic drive(input logic [NUM_CH-1:0] en, input logic [NUM_CH-1:0] vld,
                       input logic rdy, input logic clr, input logic rst);
    ch_en_i      = en;
    ch_valid_i   = vld;
    udma_ready_i = rdy;
    cfg_clr_i    = clr;
    rst_i        = rst;
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    for (int i = 0; i < NUM_CH; i++) addr_gen[i] = AW'(32'h1000 * (i + 1));
    ch_data_i = '0;
    pack_addr();
    m_ptr   = 0;
    m_stall = 0;
    drive('0, '0, 1'b0, 1'b0, 1'b1);
    repeat (2) @(posedge clk);
    #1;

    // Reset state, still in reset for one checked cycle.
    cycle();
    drive('0, '0, 1'b1, 1'b0, 1'b0);
    check("reset_valid", 64'(udma_valid_o), 64'(0));
    check("reset_data", 64'(udma_data_o), 64'(0));
    check("reset_addr", 64'(udma_addr_o), 64'(0));
    check("reset_ch", 64'(udma_ch_o), 64'(0));
    cycle();

    // Single channel, continuous traffic with addresses 0x100, 0x104, 0x108.
    addr_gen[0] = AW'(32'h100);
    rand_data();
    drive('1, 4'b0001, 1'b1, 1'b0, 1'b0);
    for (int j = 0; j < 3; j++) begin
      cycle();
      check("single_valid", 64'(udma_valid_o), 64'(1));
      check("single_addr", 64'(udma_addr_o), 64'(32'h100 + 4 * j));
    end

    // Flush, then fairness from channel 0.
    drive('1, '1, 1'b1, 1'b1, 1'b0);
    cycle();
    drive('1, '1, 1'b1, 1'b0, 1'b0);
    for (int j = 0; j < 8; j++) begin
      rand_data();
      cycle();
      check("fair_ch", 64'(udma_ch_o), 64'(j % NUM_CH));
    end

    // Backpressure: ch2 beat 0xDEADBEEF held for 5 stalled cycles.
    drive('1, '0, 1'b1, 1'b1, 1'b0);
    cycle();
    ch_data_i[2*DW +: DW] = 32'hDEADBEEF;
    drive('1, 4'b0100, 1'b1, 1'b0, 1'b0);
    cycle();
    drive('1, '1, 1'b0, 1'b0, 1'b0);
    for (int j = 0; j < 5; j++) begin
      cycle();
      check("bp_data", 64'(udma_data_o), 64'(32'hDEADBEEF));
      check("bp_ch", 64'(udma_ch_o), 64'(2));
    end
`ifdef AFE_ARB_STALL_CNT_EN
    check("bp_stall5", 64'(stall_cnt_o), 64'(5));
`endif
    drive('1, '0, 1'b1, 1'b0, 1'b0);
    cycle();
    check("bp_done", 64'(udma_valid_o), 64'(0));

    // Masking: ch1 valid but disabled, ch3 valid and enabled.
    drive('1, '0, 1'b1, 1'b1, 1'b0);
    cycle();
    drive(4'b1101, 4'b1010, 1'b1, 1'b0, 1'b0);
    for (int j = 0; j < 3; j++) begin
      cycle();
      check("mask_ch", 64'(udma_ch_o), 64'(3));
    end

    // Flush while FULL with ready=1 and ch0 requesting.
    drive('1, 4'b0001, 1'b1, 1'b0, 1'b0);
    cycle();
    drive('1, '1, 1'b1, 1'b1, 1'b0);
    cycle();
    check("flush_valid", 64'(udma_valid_o), 64'(0));
    drive('1, '1, 1'b1, 1'b0, 1'b0);
    cycle();
    check("flush_next_ch", 64'(udma_ch_o), 64'(0));

    // Reset in the middle of 4-channel traffic.
    for (int j = 0; j < 5; j++) cycle();
    drive('1, '1, 1'b1, 1'b0, 1'b1);
    cycle();
    drive('1, '1, 1'b1, 1'b0, 1'b0);
    check("rst_mid_valid", 64'(udma_valid_o), 64'(0));
    check("rst_mid_data", 64'(udma_data_o), 64'(0));
    check("rst_mid_addr", 64'(udma_addr_o), 64'(0));
    check("rst_mid_ch", 64'(udma_ch_o), 64'(0));
    for (int j = 0; j < 4; j++) begin
      cycle();
      check("rst_restart_ch", 64'(udma_ch_o), 64'(j));
    end

    // Randomized traffic.
    for (int j = 0; j < 400; j++) begin
      rand_data();
      drive(NUM_CH'($urandom) | NUM_CH'($urandom), NUM_CH'($urandom),
            ($urandom_range(0, 3) != 0), ($urandom_range(0, 29) == 0),
            ($urandom_range(0, 99) == 0));
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
